// File: rtl/ps2_key_decoder_if.sv
// +--------------------------------------------------------------------------+
// | ps2_key_decoder_if                                                       |
// | Byte-in / key-event-out bundle for the PS/2 Set-2 key decoder.           |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

interface ps2_key_decoder_if #(
  parameter int COUNT_W = 8
);
  logic [7:0]         code_in;
  logic               code_valid;
  logic               key_event;
  logic               key_make;
  logic               key_pressed;
  logic [7:0]         key_code;
  logic               key_ext;
  logic [7:0]         ascii;
  logic               shift;
  logic [COUNT_W-1:0] press_count;

  modport master (
    output code_in, code_valid,
    input  key_event, key_make, key_pressed, key_code, key_ext, ascii, shift,
           press_count
  );

  modport slave (
    input  code_in, code_valid,
    output key_event, key_make, key_pressed, key_code, key_ext, ascii, shift,
           press_count
  );
endinterface

`default_nettype wire

// File: rtl/ps2_key_decoder.sv
// +--------------------------------------------------------------------------+
// | ps2_key_decoder                                                          |
// | Resolves E0/F0 Set-2 prefixes into make/break events with ASCII mapping. |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module ps2_key_decoder #(
  parameter int COUNT_W  = 8,
  parameter bit SHIFT_EN = 1'b1
) (
  input  wire logic         clk,
  input  wire logic         resetn,
  ps2_key_decoder_if.slave  bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_E0   = 2'd1;
  localparam logic [1:0] S_F0   = 2'd2;
  localparam logic [1:0] S_E0F0 = 2'd3;

  localparam logic [7:0] C_PFX_EXT   = 8'hE0;
  localparam logic [7:0] C_PFX_BRK   = 8'hF0;
  localparam logic [7:0] C_SHIFT_L   = 8'h12;
  localparam logic [7:0] C_SHIFT_R   = 8'h59;
  localparam logic [7:0] C_CASE_DIFF = 8'h20;

  logic [1:0]         r_state;
  logic               r_shift_l;
  logic               r_shift_r;
  logic [7:0]         r_held_code;
  logic               r_held_ext;
  logic               r_key_pressed;
  logic               r_key_event;
  logic               r_key_make;
  logic [7:0]         r_key_code;
  logic               r_key_ext;
  logic [7:0]         r_ascii;
  logic [COUNT_W-1:0] r_press_count;

  logic [1:0] w_next_state;
  logic       w_make;
  logic       w_break;
  logic       w_ext;
  logic       w_is_mod;
  logic       w_held_match;
  logic [7:0] w_ascii_lc;
  logic       w_is_letter;
  logic [7:0] w_ascii;

  always_comb begin
    w_next_state = r_state;
    w_make       = 1'b0;
    w_break      = 1'b0;
    w_ext        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.code_in == C_PFX_EXT)      w_next_state = S_E0;
        else if (bus.code_in == C_PFX_BRK) w_next_state = S_F0;
        else                               w_make       = 1'b1;
      end
      S_E0: begin
        if (bus.code_in == C_PFX_BRK)      w_next_state = S_E0F0;
        else if (bus.code_in == C_PFX_EXT) w_next_state = S_E0;
        else begin
          w_make       = 1'b1;
          w_ext        = 1'b1;
          w_next_state = S_IDLE;
        end
      end
      S_F0, S_E0F0: begin
        // A prefix byte after F0 is malformed; drop it and resynchronise.
        w_next_state = S_IDLE;
        if (bus.code_in != C_PFX_EXT && bus.code_in != C_PFX_BRK) begin
          w_break = 1'b1;
          w_ext   = (r_state == S_E0F0);
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  assign w_is_mod     = !w_ext && (bus.code_in == C_SHIFT_L || bus.code_in == C_SHIFT_R);
  assign w_held_match = r_key_pressed && (r_held_code == bus.code_in) && (r_held_ext == w_ext);

  always_comb begin
    w_ascii_lc = 8'h00;
    case (bus.code_in)
      8'h1C: w_ascii_lc = 8'h61;  8'h32: w_ascii_lc = 8'h62;
      8'h21: w_ascii_lc = 8'h63;  8'h23: w_ascii_lc = 8'h64;
      8'h24: w_ascii_lc = 8'h65;  8'h2B: w_ascii_lc = 8'h66;
      8'h34: w_ascii_lc = 8'h67;  8'h33: w_ascii_lc = 8'h68;
      8'h43: w_ascii_lc = 8'h69;  8'h3B: w_ascii_lc = 8'h6A;
      8'h42: w_ascii_lc = 8'h6B;  8'h4B: w_ascii_lc = 8'h6C;
      8'h3A: w_ascii_lc = 8'h6D;  8'h31: w_ascii_lc = 8'h6E;
      8'h44: w_ascii_lc = 8'h6F;  8'h4D: w_ascii_lc = 8'h70;
      8'h15: w_ascii_lc = 8'h71;  8'h2D: w_ascii_lc = 8'h72;
      8'h1B: w_ascii_lc = 8'h73;  8'h2C: w_ascii_lc = 8'h74;
      8'h3C: w_ascii_lc = 8'h75;  8'h2A: w_ascii_lc = 8'h76;
      8'h1D: w_ascii_lc = 8'h77;  8'h22: w_ascii_lc = 8'h78;
      8'h35: w_ascii_lc = 8'h79;  8'h1A: w_ascii_lc = 8'h7A;
      8'h45: w_ascii_lc = 8'h30;  8'h16: w_ascii_lc = 8'h31;
      8'h1E: w_ascii_lc = 8'h32;  8'h26: w_ascii_lc = 8'h33;
      8'h25: w_ascii_lc = 8'h34;  8'h2E: w_ascii_lc = 8'h35;
      8'h36: w_ascii_lc = 8'h36;  8'h3D: w_ascii_lc = 8'h37;
      8'h3E: w_ascii_lc = 8'h38;  8'h46: w_ascii_lc = 8'h39;
      8'h29: w_ascii_lc = 8'h20;  8'h5A: w_ascii_lc = 8'h0D;
      default: w_ascii_lc = 8'h00;
    endcase
  end

  assign w_is_letter = (w_ascii_lc >= 8'h61) && (w_ascii_lc <= 8'h7A);

  always_comb begin
    w_ascii = w_ascii_lc;
    if (w_ext)
      w_ascii = 8'h00;
    else if (w_is_letter && SHIFT_EN && (r_shift_l || r_shift_r))
      w_ascii = w_ascii_lc - C_CASE_DIFF;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state       <= S_IDLE;
      r_shift_l     <= 1'b0;
      r_shift_r     <= 1'b0;
      r_held_code   <= 8'h00;
      r_held_ext    <= 1'b0;
      r_key_pressed <= 1'b0;
      r_key_event   <= 1'b0;
      r_key_make    <= 1'b0;
      r_key_code    <= 8'h00;
      r_key_ext     <= 1'b0;
      r_ascii       <= 8'h00;
      r_press_count <= '0;
    end else begin
      r_key_event <= 1'b0;
      if (bus.code_valid) begin
        r_state <= w_next_state;
        if (w_make || w_break) begin
          if (w_is_mod) begin
            if (bus.code_in == C_SHIFT_L) r_shift_l <= w_make;
            else                          r_shift_r <= w_make;
          end else if (w_make && !w_held_match) begin
            r_held_code   <= bus.code_in;
            r_held_ext    <= w_ext;
            r_key_pressed <= 1'b1;
            r_key_event   <= 1'b1;
            r_key_make    <= 1'b1;
            r_key_code    <= bus.code_in;
            r_key_ext     <= w_ext;
            r_ascii       <= w_ascii;
            r_press_count <= r_press_count + COUNT_W'(1);
          end else if (w_break && w_held_match) begin
            r_key_pressed <= 1'b0;
            r_key_event   <= 1'b1;
            r_key_make    <= 1'b0;
            r_key_code    <= bus.code_in;
            r_key_ext     <= w_ext;
            r_ascii       <= w_ascii;
          end
        end
      end
    end
  end

  assign bus.key_event   = r_key_event;
  assign bus.key_make    = r_key_make;
  assign bus.key_pressed = r_key_pressed;
  assign bus.key_code    = r_key_code;
  assign bus.key_ext     = r_key_ext;
  assign bus.ascii       = r_ascii;
  assign bus.shift       = r_shift_l | r_shift_r;
  assign bus.press_count = r_press_count;

endmodule

`default_nettype wire

// File: tb/tb_ps2_key_decoder.sv
// +--------------------------------------------------------------------------+
// | tb_ps2_key_decoder                                                       |
// | Directed bench driving a shifted and an unshifted decoder in lockstep.   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_ps2_key_decoder;

  logic clk;
  logic resetn;
  int   vectors;
  int   miscompares;
  int   n_make;
  int   n_break;

  ps2_key_decoder_if #(.COUNT_W(8)) bus ();
  ps2_key_decoder_if #(.COUNT_W(8)) bus_ns ();

  ps2_key_decoder #(.COUNT_W(8), .SHIFT_EN(1'b1)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  ps2_key_decoder #(.COUNT_W(8), .SHIFT_EN(1'b0)) dut_ns (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus_ns.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus_ns.code_in    = bus.code_in;
  assign bus_ns.code_valid = bus.code_valid;

  always @(negedge clk) begin
    if (resetn && bus.key_event) begin
      if (bus.key_make) n_make  = n_make + 1;
      else              n_break = n_break + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors = vectors + 1;
    assert (obs === exp) else begin
      miscompares = miscompares + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    bus.code_in    = b;
    bus.code_valid = 1'b1;
    @(negedge clk);
    bus.code_valid = 1'b0;
    #1;
  endtask

  task automatic send2(input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    bus.code_in    = a;
    bus.code_valid = 1'b1;
    @(negedge clk);
    bus.code_in    = b;
    @(negedge clk);
    bus.code_valid = 1'b0;
    #1;
  endtask

  task automatic rst_pulse();
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    #1;
  endtask

  initial begin
    int m0;
    int b0;
    vectors        = 0;
    miscompares    = 0;
    n_make         = 0;
    n_break        = 0;
    resetn         = 1'b0;
    bus.code_in    = 8'h1C;
    bus.code_valid = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_event", bus.key_event, 1'b0);
    chk("rst_pressed", bus.key_pressed, 1'b0);
    chk("rst_count", bus.press_count, 8'd0);
    chk("rst_outs", {bus.key_make, bus.key_code, bus.key_ext, bus.ascii, bus.shift}, 19'd0);
    bus.code_valid = 1'b0;
    resetn = 1'b1;

    // Plain press and release
    send(8'h1C);
    chk("t1_make_ev", {bus.key_event, bus.key_make}, 2'b11);
    chk("t1_code", bus.key_code, 8'h1C);
    chk("t1_ascii", bus.ascii, 8'h61);
    chk("t1_count", bus.press_count, 8'd1);
    chk("t1_pressed", bus.key_pressed, 1'b1);
    send(8'hF0);
    chk("t1_f0_noev", bus.key_event, 1'b0);
    send(8'h1C);
    chk("t1_break_ev", {bus.key_event, bus.key_make}, 2'b10);
    chk("t1_rel", bus.key_pressed, 1'b0);
    chk("t1_count2", bus.press_count, 8'd1);

    // Typematic repeat suppression
    m0 = n_make; b0 = n_break;
    send(8'h1C); send(8'h1C); send(8'h1C);
    chk("t2_rep_noev", bus.key_event, 1'b0);
    send(8'hF0); send(8'h1C);
    chk("t2_makes", n_make - m0, 1);
    chk("t2_breaks", n_break - b0, 1);
    chk("t2_count", bus.press_count, 8'd2);

    // Shift handling
    m0 = n_make; b0 = n_break;
    send(8'h12);
    chk("t3_shift", bus.shift, 1'b1);
    chk("t3_mod_noev", bus.key_event, 1'b0);
    send(8'h1C);
    chk("t3_upper", bus.ascii, 8'h41);
    chk("t3_noshift_en", bus_ns.ascii, 8'h61);
    chk("t3_ns_shift", bus_ns.shift, 1'b1);
    send(8'hF0); send(8'h1C);
    send(8'hF0); send(8'h12);
    chk("t3_unshift", bus.shift, 1'b0);
    chk("t3_evs", {n_make - m0, n_break - b0}, {32'd1, 32'd1});
    chk("t3_count", bus.press_count, 8'd3);

    // Extended key
    send(8'hE0); send(8'h75);
    chk("t4_make", {bus.key_event, bus.key_make, bus.key_ext}, 3'b111);
    chk("t4_code", bus.key_code, 8'h75);
    chk("t4_ascii", bus.ascii, 8'h00);
    chk("t4_count", bus.press_count, 8'd4);
    send(8'hE0); send(8'hF0); send(8'h75);
    chk("t4_break", {bus.key_event, bus.key_make, bus.key_ext}, 3'b101);

    // Counter wrap after 256 presses
    rst_pulse();
    for (int i = 0; i < 256; i++) begin
      send(8'h16);
      if (i == 254) chk("t5_count255", bus.press_count, 8'd255);
      send(8'hF0); send(8'h16);
    end
    chk("t5_wrap", bus.press_count, 8'd0);
    chk("t5_ascii", bus.ascii, 8'h31);
    m0 = n_make; b0 = n_break;
    send(8'hF0); send(8'hE0);
    chk("t5_proto_err", {n_make - m0, n_break - b0}, 64'd0);
    send(8'h29);
    chk("t5_space", {bus.key_event, bus.key_ext, bus.ascii}, {1'b1, 1'b0, 8'h20});
    chk("t5_count1", bus.press_count, 8'd1);

    // Reset discards a pending break prefix
    send(8'hF0);
    rst_pulse();
    chk("t6_rst_count", bus.press_count, 8'd0);
    send(8'h1C);
    chk("t6_make", {bus.key_event, bus.key_make, bus.key_pressed}, 3'b111);
    chk("t6_count", bus.press_count, 8'd1);

    // Rollover and back-to-back bytes
    send(8'h32);
    chk("t6_roll_ascii", bus.ascii, 8'h62);
    chk("t6_roll_count", bus.press_count, 8'd2);
    m0 = n_make; b0 = n_break;
    send2(8'hF0, 8'h1C);
    chk("t6_stale_brk", {n_break - b0, 31'd0, bus.key_pressed}, {32'd0, 32'd1});
    send2(8'hF0, 8'h32);
    chk("t6_b2b_break", {bus.key_event, bus.key_make, bus.key_pressed}, 3'b100);
    chk("t6_b2b_code", bus.key_code, 8'h32);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
